// File: rtl/btn_debounce_multi.sv
// N-channel button conditioner: 2-FF sync, tick-sampled debounce, press/release edges,
// and a per-channel hold FSM generating long-press and auto-repeat pulses.
module btn_debounce_multi #(
    parameter int unsigned N_BTN          = 4,
    parameter int unsigned SAMPLE_DIV     = 1000,
    parameter int unsigned STABLE_SAMPLES = 8,
    parameter int unsigned LONG_TICKS     = 50000,
    parameter int unsigned REPEAT_TICKS   = 10000,
    parameter int unsigned REPEAT_EN      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long,
    output logic [N_BTN-1:0] o_repeat
);

    localparam int unsigned DIV_W      = $clog2(SAMPLE_DIV) + 1;
    localparam int unsigned DB_W       = $clog2(STABLE_SAMPLES) + 1;
    localparam int unsigned HOLD_LIMIT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned H_W        = $clog2(HOLD_LIMIT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } state_t;

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level_d;
    logic [DB_W-1:0]  r_dbcnt [N_BTN];
    logic [H_W-1:0]   r_hcnt  [N_BTN];
    state_t           r_state [N_BTN];
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_fall;

    assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Level flips only after STABLE_SAMPLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_level   <= '0;
            r_level_d <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                r_dbcnt[i] <= '0;
            end
        end else begin
            r_level_d <= o_level;
            if (w_tick) begin
                for (int unsigned i = 0; i < N_BTN; i++) begin
                    if (r_sync2[i] != o_level[i]) begin
                        if (r_dbcnt[i] == DB_W'(STABLE_SAMPLES - 1)) begin
                            o_level[i] <= r_sync2[i];
                            r_dbcnt[i] <= '0;
                        end else begin
                            r_dbcnt[i] <= r_dbcnt[i] + DB_W'(1);
                        end
                    end else begin
                        r_dbcnt[i] <= '0;
                    end
                end
            end
        end
    end

    assign w_rise = o_level & ~r_level_d;
    assign w_fall = ~o_level & r_level_d;

    // Release is checked first so it overrides a long/repeat due in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_press   <= '0;
            o_release <= '0;
            o_long    <= '0;
            o_repeat  <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                r_state[i] <= ST_IDLE;
                r_hcnt[i]  <= '0;
            end
        end else begin
            o_press   <= w_rise;
            o_release <= w_fall;
            o_long    <= '0;
            o_repeat  <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (w_fall[i]) begin
                    r_state[i] <= ST_IDLE;
                    r_hcnt[i]  <= '0;
                end else begin
                    case (r_state[i])
                        ST_IDLE: begin
                            if (w_rise[i]) begin
                                r_state[i] <= ST_PRESSED;
                                r_hcnt[i]  <= '0;
                            end
                        end
                        ST_PRESSED: begin
                            if (w_tick) begin
                                if (r_hcnt[i] == H_W'(LONG_TICKS - 1)) begin
                                    o_long[i]  <= 1'b1;
                                    r_hcnt[i]  <= '0;
                                    r_state[i] <= ST_HELD;
                                end else begin
                                    r_hcnt[i] <= r_hcnt[i] + H_W'(1);
                                end
                            end
                        end
                        ST_HELD: begin
                            if (w_tick) begin
                                if (r_hcnt[i] == H_W'(REPEAT_TICKS - 1)) begin
                                    o_repeat[i] <= (REPEAT_EN != 0);
                                    r_hcnt[i]   <= '0;
                                end else begin
                                    r_hcnt[i] <= r_hcnt[i] + H_W'(1);
                                end
                            end
                        end
                        default: begin
                            r_state[i] <= ST_IDLE;
                            r_hcnt[i]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: table-driven segments, hand-written corner sequences,
// random stimulus, all cross-checked cycle by cycle against an event-level reference model.
module tb_btn_debounce_multi;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int ST = 3;
    localparam int LT = 5;
    localparam int RT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] lvl0, prs0, rel0, lng0, rep0;
    logic [N-1:0] lvl1, prs1, rel1, lng1, rep1;

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .N_BTN(N), .SAMPLE_DIV(SD), .STABLE_SAMPLES(ST),
        .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1)
    ) dut0 (
        .clk(clk), .rst(rst), .i_btn(btn),
        .o_level(lvl0), .o_press(prs0), .o_release(rel0), .o_long(lng0), .o_repeat(rep0)
    );

    btn_debounce_multi #(
        .N_BTN(N), .SAMPLE_DIV(SD), .STABLE_SAMPLES(ST),
        .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(0)
    ) dut1 (
        .clk(clk), .rst(rst), .i_btn(btn),
        .o_level(lvl1), .o_press(prs1), .o_release(rel1), .o_long(lng1), .o_repeat(rep1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_v(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ticks from an edge count, sync as a 2-deep queue,
    // hold gestures from "ticks elapsed since press" arithmetic.
    logic [N-1:0] m_pipe[$];
    int           m_edge;
    int           m_run  [N];
    int           m_hold [N];
    bit           m_held [N];
    logic [N-1:0] m_lvl, m_lvl_prev;
    logic [N-1:0] e_lvl = '0, e_prs = '0, e_rel = '0, e_lng = '0, e_rep = '0;
    bit           m_live = 1'b0;

    always @(posedge clk) begin
        logic [N-1:0] s, p, r;
        bit tick;
        if (!rst) begin
            m_pipe.delete();
            m_pipe.push_back('0);
            m_pipe.push_back('0);
            m_edge = 0;
            m_lvl = '0;
            m_lvl_prev = '0;
            for (int ch = 0; ch < N; ch++) begin
                m_run[ch] = 0; m_hold[ch] = 0; m_held[ch] = 1'b0;
            end
            e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_rep = '0;
            m_live = 1'b1;
        end else begin
            m_edge++;
            tick = ((m_edge - 1) % SD) == SD - 1;
            s = m_pipe.pop_front();
            m_pipe.push_back(btn);
            p = m_lvl & ~m_lvl_prev;
            r = ~m_lvl & m_lvl_prev;
            e_lng = '0;
            e_rep = '0;
            for (int ch = 0; ch < N; ch++) begin
                if (r[ch]) begin
                    m_held[ch] = 1'b0;
                end else if (m_held[ch] && tick) begin
                    m_hold[ch]++;
                    if (m_hold[ch] == LT) e_lng[ch] = 1'b1;
                    else if (m_hold[ch] > LT && ((m_hold[ch] - LT) % RT) == 0) e_rep[ch] = 1'b1;
                end
                if (p[ch]) begin
                    m_held[ch] = 1'b1;
                    m_hold[ch] = 0;
                end
            end
            m_lvl_prev = m_lvl;
            if (tick) begin
                for (int ch = 0; ch < N; ch++) begin
                    if (s[ch] != m_lvl[ch]) begin
                        m_run[ch]++;
                        if (m_run[ch] == ST) begin
                            m_lvl[ch] = s[ch];
                            m_run[ch] = 0;
                        end
                    end else begin
                        m_run[ch] = 0;
                    end
                end
            end
            e_lvl = m_lvl;
            e_prs = p;
            e_rel = r;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk_v("level",      lvl0, e_lvl);
            chk_v("press",      prs0, e_prs);
            chk_v("release",    rel0, e_rel);
            chk_v("long",       lng0, e_lng);
            chk_v("repeat",     rep0, e_rep);
            chk_v("level_nr",   lvl1, e_lvl);
            chk_v("press_nr",   prs1, e_prs);
            chk_v("release_nr", rel1, e_rel);
            chk_v("long_nr",    lng1, e_lng);
            chk_v("repeat_nr",  rep1, '0);
        end
    end

    int c_press [N];
    int c_rel   [N];
    int c_long, c_rep, c_rep1, c_pat, c_pany;

    task automatic clr();
        for (int ch = 0; ch < N; ch++) begin
            c_press[ch] = 0; c_rel[ch] = 0;
        end
        c_long = 0; c_rep = 0; c_rep1 = 0; c_pat = 0; c_pany = 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int ch = 0; ch < N; ch++) begin
                c_press[ch] += int'(prs0[ch]);
                c_rel[ch]   += int'(rel0[ch]);
                c_long      += int'(lng0[ch]);
                c_rep       += int'(rep0[ch]);
                c_rep1      += int'(rep1[ch]);
            end
            if (prs0 == 4'b1001) c_pat++;
            if (prs0 != '0) c_pany++;
        end
    endtask

    function automatic int sum4(input int a [N]);
        int t = 0;
        for (int ch = 0; ch < N; ch++) t += a[ch];
        return t;
    endfunction

    task automatic drive(input bit r, input logic [N-1:0] b);
        #1;
        rst = r;
        btn = b;
    endtask

    typedef struct {
        bit           rst_n;
        logic [N-1:0] btn;
        int           cycles;
        logic [N-1:0] lvl;
        int           np, nr, nl, nrep;
    } vec_t;

    initial begin
        vec_t tbl [6];
        tbl[0] = '{1'b0, 4'hF, 10, 4'h0, 0, 0, 0, 0};
        tbl[1] = '{1'b1, 4'hF, 20, 4'hF, 4, 0, 0, 0};
        tbl[2] = '{1'b1, 4'hF, 16, 4'hF, 0, 0, 4, 0};
        tbl[3] = '{1'b1, 4'hF, 16, 4'hF, 0, 0, 0, 8};
        tbl[4] = '{1'b1, 4'h0, 24, 4'h0, 0, 4, 0, 8};
        tbl[5] = '{1'b1, 4'h0, 8,  4'h0, 0, 0, 0, 0};

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].rst_n, tbl[i].btn);
            clr();
            run(tbl[i].cycles);
            chk_v("tbl_level",   lvl0, tbl[i].lvl);
            chk_i("tbl_press",   sum4(c_press), tbl[i].np);
            chk_i("tbl_release", sum4(c_rel), tbl[i].nr);
            chk_i("tbl_long",    c_long, tbl[i].nl);
            chk_i("tbl_repeat",  c_rep, tbl[i].nrep);
            chk_i("tbl_repeat_nr", c_rep1, 0);
        end

        clr();
        for (int k = 0; k < 13; k++) begin
            drive(1'b1, btn ^ 4'h1);
            run(3);
        end
        chk_i("bounce_press", c_press[0], 0);
        clr();
        run(40);
        chk_i("bounce_settle_press", c_press[0], 1);
        chk_i("bounce_level", int'(lvl0[0]), 1);

        clr();
        drive(1'b1, btn | 4'h2);
        run(8);
        drive(1'b1, btn & ~4'h2);
        run(24);
        chk_i("glitch_press",   c_press[1], 0);
        chk_i("glitch_release", c_rel[1], 0);
        chk_i("glitch_level",   int'(lvl0[1]), 0);

        drive(1'b1, 4'h0);
        run(30);
        clr();
        drive(1'b1, 4'h9);
        run(30);
        chk_i("simul_pattern", c_pat, 1);
        chk_i("simul_any",     c_pany, 1);
        run(20);
        drive(1'b0, 4'h9);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_v("rst_level",   lvl0, '0);
            chk_v("rst_press",   prs0, '0);
            chk_v("rst_release", rel0, '0);
            chk_v("rst_long",    lng0, '0);
            chk_v("rst_repeat",  rep0, '0);
        end
        drive(1'b1, 4'h9);
        clr();
        run(25);
        chk_i("post_rst_pattern", c_pat, 1);
        chk_i("post_rst_any",     c_pany, 1);

        for (int k = 0; k < 60; k++) begin
            drive($urandom_range(0, 19) != 0, N'($urandom));
            run(int'($urandom_range(1, 24)));
        end
        drive(1'b1, 4'h0);
        run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
